seq_det: RTL and testbench
==========================

SEQ_DET -- requirements
Module: seq_det

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port din, input, 1 bit: serial data bit, normally driven by the upstream single-bit register stage.
REQ-005 The block SHALL have port din_vld, input, 1 bit: din is sampled only on edges where din_vld=1.
REQ-006 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-007 The block SHALL have port match, output, 1 bit: registered one-cycle pulse on detection of pattern 1011.
REQ-008 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of detections.
REQ-009 The block SHALL have port state, output, 2 bits: current FSM state, for debug.

Function
REQ-010 The block SHALL detect the serial pattern 1 0 1 1 (first-received bit first), with overlapping matches permitted.
REQ-011 The FSM SHALL have four states, encoded S0=2'd0 (no prefix), S1=2'd1 ("1"), S10=2'd2 ("10") and S101=2'd3 ("101").
REQ-012 The S0 transitions SHALL be: din=1 -> S1; din=0 -> S0.
REQ-013 The S1 transitions SHALL be: din=1 -> S1; din=0 -> S10.
REQ-014 The S10 transitions SHALL be: din=1 -> S101; din=0 -> S0.
REQ-015 The S101 transitions SHALL be: din=1 -> S1, which is a match; din=0 -> S10.
REQ-016 Transitions SHALL occur only on rising edges with din_vld=1; with din_vld=0 the state SHALL hold and din SHALL be ignored.
REQ-017 Latency: match SHALL be 1 for exactly the one cycle following the rising edge that samples the completing bit, and 0 otherwise.
REQ-018 Back-to-back detections SHALL be supported: the stream 1011011 yields two match pulses, after bit 4 and after bit 7.
REQ-019 match SHALL never stay high for two consecutive cycles, including when din_vld gaps occur.
REQ-020 match_cnt SHALL increment by 1 on each edge that produces a match.
REQ-021 match_cnt SHALL saturate at 2^CNT_W-1; further matches leave it unchanged and still pulse match.
REQ-022 cnt_clr=1 SHALL set match_cnt to 0 on that edge, taking priority over a simultaneous increment; the FSM and match are unaffected.
REQ-023 state SHALL reflect the registered FSM state, with no combinational path from din.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 With rst=1 at a rising edge, the FSM SHALL go to S0, match to 0 and match_cnt to 0.
REQ-026 rst SHALL take priority over din_vld and cnt_clr.
REQ-027 Reset applied mid-pattern, such as in S101, SHALL discard the partial prefix, and no match SHALL result from bits straddling reset.
REQ-028 Before the first reset, output values are undefined; the bench SHALL apply rst for at least 2 cycles at start.

Verification
REQ-029 The bench SHALL drive din_vld=1 with din=1,0,1,1 on consecutive edges -> match=1 for one cycle after the 4th edge, match_cnt=1, and state sequence 1,2,3,1.
REQ-030 The bench SHALL drive din_vld=1 with din=1,0,1,1,0,1,1 -> two match pulses, after edges 4 and 7, and match_cnt=2.
REQ-031 The bench SHALL drive bits 1,0,1 with din_vld=1, then 3 cycles of din_vld=0 with din toggling, then 1 with din_vld=1 -> state holds at 3 during the gap, then a single match, match_cnt=1.
REQ-032 The bench SHALL drive 1,0,1, then rst=1 for 1 cycle, then 1 -> no match, state=1, match_cnt=0.
REQ-033 With CNT_W=2, the bench SHALL drive 4 matches -> match_cnt goes 1,2,3,3; then cnt_clr=1 on the same edge as a 5th match -> match=1 and match_cnt=0.
REQ-034 The bench SHALL drive the stream 1,1,0,1,0,1,1 -> exactly one match after the 7th bit, and never a match on 0-terminated prefixes.

Source files
------------

// File: rtl/seq_det.sv
// Serial detector for the pattern 1011 (first bit first), overlapping matches allowed.
// Produces a registered one-cycle match pulse and a saturating, clearable match counter.
module seq_det #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [1:0]       state
);

  localparam int unsigned ST_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [ST_W-1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S10  = 2'd2,
    S101 = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   match_d;

  // State register; no transition without a valid sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and match detection for the sampled bit
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        S0:   state_d = din ? S1   : S0;
        S1:   state_d = din ? S1   : S10;
        S10:  state_d = din ? S101 : S0;
        S101: begin
          state_d = din ? S1 : S10;
          match_d = din;
        end
        default: state_d = S0;
      endcase
    end
  end

  // Match pulse and saturating counter; clear wins over a same-edge increment
  always_ff @(posedge clk) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= match_d;
      if (cnt_clr) begin
        match_cnt <= '0;
      end else if (match_d && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

  assign state = ST_W'(state_q);

endmodule

// File: tb/tb_seq_det.sv
// Scoreboard bench for seq_det: stimulus queues hand-computed per-cycle expectations,
// a monitor pops and compares them after every rising edge.
module tb_seq_det;

  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_vld = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [1:0]       state;

  typedef struct packed {
    logic             m;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       st;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cycle = 0;

  seq_det #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .cnt_clr  (cnt_clr),
    .match    (match),
    .match_cnt(match_cnt),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs and queue what the outputs must be after it
  task automatic step(input logic r, input logic v, input logic d, input logic c,
                      input logic m, input int cnt, input int st);
    exp_t e;
    @(negedge clk);
    rst     = r;
    din_vld = v;
    din     = d;
    cnt_clr = c;
    e.m   = m;
    e.cnt = CNT_W'(cnt);
    e.st  = 2'(st);
    q.push_back(e);
  endtask

  // Monitor: compare every registered output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cycle++;
        n_tests++;
        if (match !== e.m) begin
          n_fail++;
          $display("FAIL match @chk%0d: got %0b expected %0b", n_cycle, match, e.m);
        end
        n_tests++;
        if (match_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL match_cnt @chk%0d: got %0d expected %0d", n_cycle, match_cnt, e.cnt);
        end
        n_tests++;
        if (state !== e.st) begin
          n_fail++;
          $display("FAIL state @chk%0d: got %0d expected %0d", n_cycle, state, e.st);
        end
      end
    end
  end

  initial begin
    //    rst vld din clr | match cnt state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Single match 1011
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Overlapping 1011011
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 1, 2);
    step(0, 1, 1, 0, 0, 1, 3);
    step(0, 1, 1, 0, 1, 2, 1);
    step(0, 0, 0, 0, 0, 2, 1);

    // din_vld gap with toggling din inside 101_1
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    step(0, 0, 1, 0, 0, 0, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1);

    // Reset mid-pattern (rst wins over a valid 1), no straddling match
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // 1101011: single match on the last bit only
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // Saturation at 3 with CNT_W=2, then clear on a matching edge
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0, 3);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 0, 0, 0, 1, 2);
    step(0, 1, 1, 0, 0, 1, 3);
    step(0, 1, 1, 0, 1, 2, 1);
    step(0, 1, 0, 0, 0, 2, 2);
    step(0, 1, 1, 0, 0, 2, 3);
    step(0, 1, 1, 0, 1, 3, 1);
    step(0, 1, 0, 0, 0, 3, 2);
    step(0, 1, 1, 0, 0, 3, 3);
    step(0, 1, 1, 0, 1, 3, 1);
    step(0, 1, 0, 0, 0, 3, 2);
    step(0, 1, 1, 0, 0, 3, 3);
    step(0, 1, 1, 1, 1, 0, 1);
    step(0, 1, 0, 1, 0, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2);

    // Drain the scoreboard, bounded
    @(negedge clk);
    rst = 1'b0; din_vld = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
